vending_machine: RTL and testbench
==================================

// Module: vending_machine
// PURPOSE
//   Four-product vending machine controller. Accumulates coin credit, sells the
//   one-hot selected product on a buy request when credit and stock suffice,
//   and tracks per-product stock with a restock (load) input.
//   Sits between front-panel inputs (coins, select, buy, load) and dispense/display logic.
// PARAMETERS
//   COIN1_VALUE  5     credit added per coin1 event
//   COIN2_VALUE  10    credit added per coin2 event
//   PRICE0..3    15,20,25,30  price of product slot 0..3
//   STOCK_MAX    15    stock per slot after reset/load (1..15)
// PORTS
//   clk         in   1   single clock, all logic on rising edge
//   rst         in   1   synchronous, active-high reset
//   coin1       in   1   coin type 1 inserted (level; rising edge counts)
//   coin2       in   1   coin type 2 inserted (level; rising edge counts)
//   select      in   4   one-hot product select (bit i = slot i)
//   buy         in   1   purchase request (level; rising edge counts)
//   load        in   4   per-slot restock request, bit i refills slot i
//   money       out  12  current credit, unsigned binary
//   products    out  4   one-hot dispense pulse, one cycle wide
//   outofstock  out  4   bit i high while stock of slot i == 0
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): money=0, products=0, all stock=STOCK_MAX,
//     outofstock=0; coin1/coin2/buy edge-detect registers load current input
//     levels so inputs held through reset never count.
//   - Event = input sampled 1 at this edge, 0 at previous edge. One event per assertion.
//   - All registered; effects visible after the edge that detects the event (latency 1).
//   - Coins: credit += COIN1_VALUE and/or COIN2_VALUE; both in same cycle add both.
//     Credit saturates at 4095, never wraps.
//   - Buy event: valid only if select has exactly one bit set (slot i),
//     stock[i] > 0 and money >= PRICEi. Valid -> money -= PRICEi, stock[i] -= 1,
//     products = 1<<i for exactly one cycle. Invalid -> no state change, products=0.
//   - products = 0 in every cycle without a valid buy.
//   - Coin and buy in same cycle: buy checked against pre-coin credit;
//     next money = money - price(if valid) + coin values (saturated).
//   - load[i]=1: stock[i] = STOCK_MAX next cycle; overrides a same-cycle
//     decrement of slot i (buy still judged on old stock).
//   - outofstock[i] = (stock[i]==0), derived from registered stock.
//   - Remaining credit after a sale is retained (no change/refund output).
//   - select changes without buy have no effect; buy held high does not repeat.
// TESTING
//   1 rst 1 cycle -> money=0, products=0, outofstock=0.
//   2 coin1, coin2, coin1, coin2 pulses -> money 5,15,20,30 (0x01E).
//   3 credit 30, select=4'b0100, buy rising -> products=4'b0100 one cycle,
//     money=5.
//   4 credit 5, select=4'b0010, buy rising -> products stays 0, money=5.
//   5 buy slot 0 STOCK_MAX times with ample credit -> outofstock[0]=1,
//     next buy refused; load=4'b0001 -> outofstock[0]=0.
//   6 select=4'b0110 + buy -> refused; coin1 high through reset -> money=0 after.

Source files
------------

// File: rtl/vending_machine.sv
// Four-slot vending controller: rising-edge coin/buy detection, saturating credit,
// per-slot stock with restock, and a one-cycle one-hot dispense pulse.
module vending_machine #(
  parameter int unsigned COIN1_VALUE = 5,
  parameter int unsigned COIN2_VALUE = 10,
  parameter int unsigned PRICE0      = 15,
  parameter int unsigned PRICE1      = 20,
  parameter int unsigned PRICE2      = 25,
  parameter int unsigned PRICE3      = 30,
  parameter int unsigned STOCK_MAX   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin1,
  input  logic        coin2,
  input  logic [3:0]  select,
  input  logic        buy,
  input  logic [3:0]  load,
  output logic [11:0] money,
  output logic [3:0]  products,
  output logic [3:0]  outofstock
);

  localparam logic [3:0] STOCK_FULL = 4'(STOCK_MAX);

  logic        r_coin1_d;
  logic        r_coin2_d;
  logic        r_buy_d;
  logic [11:0] r_money;
  logic [3:0]  r_products;
  logic [3:0]  r_stock [4];

  logic        w_coin1_ev;
  logic        w_coin2_ev;
  logic        w_buy_ev;
  logic        w_onehot;
  logic [1:0]  w_slot;
  logic [11:0] w_price;
  logic        w_valid;
  logic [13:0] w_money_sum;
  logic [11:0] w_money_next;

  function automatic logic [11:0] sat12(input logic [13:0] v);
    return (v > 14'd4095) ? 12'hFFF : v[11:0];
  endfunction

  assign w_coin1_ev = coin1 & ~r_coin1_d;
  assign w_coin2_ev = coin2 & ~r_coin2_d;
  assign w_buy_ev   = buy & ~r_buy_d;
  assign w_onehot   = (select != 4'd0) && ((select & (select - 4'd1)) == 4'd0);

  always_comb begin
    w_slot  = 2'd0;
    w_price = 12'(PRICE0);
    case (select)
      4'b0010: begin w_slot = 2'd1; w_price = 12'(PRICE1); end
      4'b0100: begin w_slot = 2'd2; w_price = 12'(PRICE2); end
      4'b1000: begin w_slot = 2'd3; w_price = 12'(PRICE3); end
      default: begin w_slot = 2'd0; w_price = 12'(PRICE0); end
    endcase
  end

  // Buy is judged against pre-coin credit and pre-load stock.
  assign w_valid = w_buy_ev && w_onehot && (r_stock[w_slot] != 4'd0) && (r_money >= w_price);

  assign w_money_sum = {2'b00, (w_valid ? (r_money - w_price) : r_money)}
                     + (w_coin1_ev ? 14'(COIN1_VALUE) : 14'd0)
                     + (w_coin2_ev ? 14'(COIN2_VALUE) : 14'd0);
  assign w_money_next = sat12(w_money_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_coin1_d  <= coin1;
      r_coin2_d  <= coin2;
      r_buy_d    <= buy;
      r_money    <= 12'd0;
      r_products <= 4'd0;
      for (int i = 0; i < 4; i++) r_stock[i] <= STOCK_FULL;
    end else begin
      r_coin1_d  <= coin1;
      r_coin2_d  <= coin2;
      r_buy_d    <= buy;
      r_money    <= w_money_next;
      r_products <= w_valid ? select : 4'd0;
      for (int i = 0; i < 4; i++) begin
        if (load[i])
          r_stock[i] <= STOCK_FULL;
        else if (w_valid && (w_slot == 2'(i)))
          r_stock[i] <= r_stock[i] - 4'd1;
      end
    end
  end

  assign money    = r_money;
  assign products = r_products;
  always_comb begin
    outofstock = 4'd0;
    for (int i = 0; i < 4; i++) outofstock[i] = (r_stock[i] == 4'd0);
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: credit, sales, refusals, stock depletion,
// restock, saturation and reset behaviour against hand-computed values.
module tb_vending_machine;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin1;
  logic        coin2;
  logic [3:0]  select;
  logic        buy;
  logic [3:0]  load;
  logic [11:0] money;
  logic [3:0]  products;
  logic [3:0]  outofstock;

  int errors = 0;
  int checks = 0;

  vending_machine dut (
    .clk        (clk),
    .rst        (rst),
    .coin1      (coin1),
    .coin2      (coin2),
    .select     (select),
    .buy        (buy),
    .load       (load),
    .money      (money),
    .products   (products),
    .outofstock (outofstock)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_coin1();
    coin1 = 1'b1; tick(); coin1 = 1'b0; tick();
  endtask

  task automatic pulse_coin2();
    coin2 = 1'b1; tick(); coin2 = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; coin1 = 1'b0; coin2 = 1'b0; select = 4'd0; buy = 1'b0; load = 4'd0;
    tick(); tick();
    chk("rst_money", 32'(money), 0);
    chk("rst_products", 32'(products), 0);
    chk("rst_outofstock", 32'(outofstock), 0);
    rst = 1'b0;
    tick();

    pulse_coin1(); chk("coin_a", 32'(money), 5);
    pulse_coin2(); chk("coin_b", 32'(money), 15);
    pulse_coin1(); chk("coin_c", 32'(money), 20);
    pulse_coin2(); chk("coin_d", 32'(money), 30);

    // Sale of slot 2 (price 25); holding buy must not repeat.
    select = 4'b0100; buy = 1'b1; tick();
    chk("buy2_products", 32'(products), 32'b0100);
    chk("buy2_money", 32'(money), 5);
    tick();
    chk("buy2_held_products", 32'(products), 0);
    chk("buy2_held_money", 32'(money), 5);
    buy = 1'b0; tick();

    // Insufficient credit for slot 1.
    select = 4'b0010; buy = 1'b1; tick();
    chk("poor_products", 32'(products), 0);
    chk("poor_money", 32'(money), 5);
    buy = 1'b0; tick();

    // Both coins in one cycle.
    coin1 = 1'b1; coin2 = 1'b1; tick();
    chk("two_coins", 32'(money), 20);
    coin1 = 1'b0; coin2 = 1'b0; tick();

    // Buy with coin in same cycle: 20 - 15 + 5.
    select = 4'b0001; buy = 1'b1; coin1 = 1'b1; tick();
    chk("buycoin_products", 32'(products), 32'b0001);
    chk("buycoin_money", 32'(money), 10);
    buy = 1'b0; coin1 = 1'b0; tick();
    chk("pulse_width", 32'(products), 0);

    // Pre-coin credit 10 < 15: refused, coin still credited.
    buy = 1'b1; coin2 = 1'b1; tick();
    chk("precoin_products", 32'(products), 0);
    chk("precoin_money", 32'(money), 20);
    buy = 1'b0; coin2 = 1'b0; tick();

    // Deplete slot 0 (14 left) with ample credit: 20 + 300 - 210 = 110.
    for (int i = 0; i < 30; i++) pulse_coin2();
    chk("pump_money", 32'(money), 320);
    for (int i = 0; i < 14; i++) begin
      buy = 1'b1; tick();
      chk("deplete_products", 32'(products), 32'b0001);
      buy = 1'b0; tick();
    end
    chk("deplete_money", 32'(money), 110);
    chk("empty_flag", 32'(outofstock), 32'b0001);
    buy = 1'b1; tick();
    chk("empty_products", 32'(products), 0);
    chk("empty_money", 32'(money), 110);
    buy = 1'b0; tick();
    load = 4'b0001; tick();
    load = 4'b0000;
    chk("restock_flag", 32'(outofstock), 0);
    tick();

    // Multi-hot select refused.
    select = 4'b0110; buy = 1'b1; tick();
    chk("multihot_products", 32'(products), 0);
    chk("multihot_money", 32'(money), 110);
    buy = 1'b0; tick();

    // Saturation at 4095.
    for (int i = 0; i < 420; i++) pulse_coin2();
    chk("sat_money", 32'(money), 4095);
    select = 4'b1000; buy = 1'b1; coin2 = 1'b1; tick();
    chk("sat_buy_products", 32'(products), 32'b1000);
    chk("sat_buy_money", 32'(money), 4075);
    buy = 1'b0; coin2 = 1'b0; tick();

    // Coin held through reset must not count.
    coin1 = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("held_coin_money", 32'(money), 0);
    coin1 = 1'b0; tick();
    chk("held_coin_money2", 32'(money), 0);
    chk("post_rst_outofstock", 32'(outofstock), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
